// File: rtl/qck_gate_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : qck_gate_sequencer_if
//  Description : Control/status bundle between the CA/QCA control logic
//                (master) and the QCK gate sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface qck_gate_sequencer_if #(
    parameter int CHANNELS      = 8,
    parameter int DELAY_WIDTH   = 4,
    parameter int ERR_CNT_WIDTH = 8
);
    // Requests and configuration from the control logic
    logic [CHANNELS-1:0]             ck_en;
    logic [CHANNELS-1:0]             qck_mask;
    logic [CHANNELS-1:0]             skip_req;
    logic [CHANNELS*DELAY_WIDTH-1:0] wake_delay;
    logic [CHANNELS*DELAY_WIDTH-1:0] sleep_delay;
    logic                            err_clr;

    // Gate enables and status back from the sequencer
    logic [CHANNELS-1:0]             ck_gate;
    logic [CHANNELS*2-1:0]           ch_state;
    logic [CHANNELS-1:0]             error;
    logic [ERR_CNT_WIDTH-1:0]        err_count;
    logic                            busy;

    modport master (
        output ck_en, qck_mask, skip_req, wake_delay, sleep_delay, err_clr,
        input  ck_gate, ch_state, error, err_count, busy
    );

    modport slave (
        input  ck_en, qck_mask, skip_req, wake_delay, sleep_delay, err_clr,
        output ck_gate, ch_state, error, err_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/qck_gate_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qck_gate_sequencer
//  Description : DDR5 QCK dynamic clock-gating controller. One OFF/WAKE/ON/
//                SLEEP state machine per channel with independently latched
//                wake and sleep delays, skip override, abort detection,
//                sticky per-channel errors and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module qck_gate_sequencer #(
    parameter int CHANNELS       = 8,
    parameter int PIPELINE_DEPTH = 2,
    parameter int DELAY_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    qck_gate_sequencer_if.slave  bus
);

    // Channel state encoding (also the ch_state output encoding)
    localparam logic [1:0] c_ST_OFF   = 2'b00;
    localparam logic [1:0] c_ST_WAKE  = 2'b01;
    localparam logic [1:0] c_ST_ON    = 2'b10;
    localparam logic [1:0] c_ST_SLEEP = 2'b11;

    // Popcount width and the widened sum used for saturation detection
    localparam int c_PCW  = $clog2(CHANNELS + 1);
    localparam int c_SUMW = ERR_CNT_WIDTH + c_PCW;

    localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_MAX = '1;
    localparam logic [DELAY_WIDTH-1:0]   c_CNT_ONE = DELAY_WIDTH'(1);

    // Input pipelines; index PIPELINE_DEPTH-1 is the stage the FSMs observe
    logic [PIPELINE_DEPTH-1:0][CHANNELS-1:0] r_en_pipe;
    logic [PIPELINE_DEPTH-1:0][CHANNELS-1:0] r_mask_pipe;
    logic [PIPELINE_DEPTH-1:0][CHANNELS-1:0] r_skip_pipe;

    logic [CHANNELS-1:0] w_en_p;
    logic [CHANNELS-1:0] w_mask_p;
    logic [CHANNELS-1:0] w_skip_p;
    logic [CHANNELS-1:0] w_req;

    // Per-channel state and delay counter
    logic [CHANNELS-1:0][1:0]             r_state;
    logic [CHANNELS-1:0][1:0]             w_state_nxt;
    logic [CHANNELS-1:0][DELAY_WIDTH-1:0] r_cnt;
    logic [CHANNELS-1:0][DELAY_WIDTH-1:0] w_cnt_nxt;

    // Registered outputs
    logic [CHANNELS-1:0]      r_gate;
    logic [CHANNELS-1:0]      r_error;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic                     r_busy;

    // Error bookkeeping
    logic [CHANNELS-1:0]      w_event;
    logic [c_PCW-1:0]         w_evt_cnt;
    logic [c_SUMW-1:0]        w_err_sum;
    logic [ERR_CNT_WIDTH-1:0] w_err_count_nxt;
    logic [CHANNELS-1:0]      w_error_nxt;

    // Shift the raw requests through the alignment pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_pipe   <= '0;
            r_mask_pipe <= '0;
            r_skip_pipe <= '0;
        end else begin
            r_en_pipe[0]   <= bus.ck_en;
            r_mask_pipe[0] <= bus.qck_mask;
            r_skip_pipe[0] <= bus.skip_req;
            for (int s = 1; s < PIPELINE_DEPTH; s++) begin
                r_en_pipe[s]   <= r_en_pipe[s-1];
                r_mask_pipe[s] <= r_mask_pipe[s-1];
                r_skip_pipe[s] <= r_skip_pipe[s-1];
            end
        end
    end

    assign w_en_p   = r_en_pipe[PIPELINE_DEPTH-1];
    assign w_mask_p = r_mask_pipe[PIPELINE_DEPTH-1];
    assign w_skip_p = r_skip_pipe[PIPELINE_DEPTH-1];
    assign w_req    = w_en_p & ~w_mask_p;

    // Next-state, delay counter and error-event decode for every channel
    always_comb begin
        logic [DELAY_WIDTH-1:0] v_wake;
        logic [DELAY_WIDTH-1:0] v_sleep;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_event     = '0;
        v_wake      = '0;
        v_sleep     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v_wake  = bus.wake_delay[i*DELAY_WIDTH +: DELAY_WIDTH];
            v_sleep = bus.sleep_delay[i*DELAY_WIDTH +: DELAY_WIDTH];

            // A skip against a mask is a conflict; dropping a request mid-wake is an abort
            w_event[i] = (w_skip_p[i] & w_mask_p[i]) |
                         ((r_state[i] == c_ST_WAKE) & ~w_req[i] & ~w_skip_p[i]);

            case (r_state[i])
                c_ST_OFF: begin
                    if (w_skip_p[i]) begin
                        w_state_nxt[i] = c_ST_ON;
                    end else if (w_req[i]) begin
                        if (v_wake == '0) begin
                            w_state_nxt[i] = c_ST_ON;
                        end else begin
                            w_state_nxt[i] = c_ST_WAKE;
                            w_cnt_nxt[i]   = v_wake;
                        end
                    end
                end
                c_ST_WAKE: begin
                    if (w_skip_p[i]) begin
                        w_state_nxt[i] = c_ST_ON;
                    end else if (!w_req[i]) begin
                        w_state_nxt[i] = c_ST_OFF;
                    end else if (r_cnt[i] == c_CNT_ONE) begin
                        w_state_nxt[i] = c_ST_ON;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - c_CNT_ONE;
                    end
                end
                c_ST_ON: begin
                    if (!(w_skip_p[i] | w_req[i])) begin
                        if (v_sleep == '0) begin
                            w_state_nxt[i] = c_ST_OFF;
                        end else begin
                            w_state_nxt[i] = c_ST_SLEEP;
                            w_cnt_nxt[i]   = v_sleep;
                        end
                    end
                end
                default: begin
                    // SLEEP: any renewed request re-arms ON and abandons the countdown
                    if (w_skip_p[i] | w_req[i]) begin
                        w_state_nxt[i] = c_ST_ON;
                    end else if (r_cnt[i] == c_CNT_ONE) begin
                        w_state_nxt[i] = c_ST_OFF;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - c_CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Count this cycle's error events and form the saturated/cleared totals
    always_comb begin
        w_evt_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_evt_cnt = w_evt_cnt + c_PCW'(w_event[i]);
        end
        // A clear restarts from zero, but the current cycle's events still count
        w_err_sum = (bus.err_clr ? '0 : c_SUMW'(r_err_count)) + c_SUMW'(w_evt_cnt);
        if (w_err_sum[c_SUMW-1:ERR_CNT_WIDTH] != '0) begin
            w_err_count_nxt = c_ERR_MAX;
        end else begin
            w_err_count_nxt = w_err_sum[ERR_CNT_WIDTH-1:0];
        end
        w_error_nxt = bus.err_clr ? w_event : (r_error | w_event);
    end

    // Register state, counters, gate enables and busy together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_gate  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                // ON and SLEEP both have bit 1 set; WAKE and SLEEP both have bit 0 set
                r_gate[i] <= w_state_nxt[i][1];
                if (w_state_nxt[i][0]) begin
                    r_busy <= 1'b1;
                end
            end
        end
    end

    // Register the sticky error flags and the saturating error count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error     <= '0;
            r_err_count <= '0;
        end else begin
            r_error     <= w_error_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign bus.ck_gate   = r_gate;
    assign bus.ch_state  = r_state;
    assign bus.error     = r_error;
    assign bus.err_count = r_err_count;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/qck_gate_sequencer.md
Name: qck_gate_sequencer

Overview:
- Next-generation DDR5 QCK dynamic clock-gating controller. Adds a per-channel gating state machine with independent programmable wake and sleep delays.
- Per-channel skip override, abort detection, sticky per-channel errors and a saturating error counter.
- Sits between the CA/QCA control logic and the QCK output drivers; ck_gate qualifies each channel's QCK.

Parameters:
- CHANNELS, 8, number of QCK channels (1..32)
- PIPELINE_DEPTH, 2, input pipeline stages on ck_en/qck_mask/skip_req (>=1)
- DELAY_WIDTH, 4, width of each wake/sleep delay field
- ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
- clk  in  1  core clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- ck_en  in  CHANNELS  per-channel clock enable request
- qck_mask  in  CHANNELS  per-channel gating mask (1 = suppress request)
- skip_req  in  CHANNELS  per-channel force-on override
- wake_delay  in  CHANNELS*DELAY_WIDTH  channel i at [i*DELAY_WIDTH +: DELAY_WIDTH], cycles OFF->ON
- sleep_delay  in  CHANNELS*DELAY_WIDTH  same packing, cycles ON->OFF
- err_clr  in  1  clears error and err_count
- ck_gate  out  CHANNELS  registered gate enable per channel
- ch_state  out  CHANNELS*2  per-channel FSM state, channel i at [2i+:2]
- error  out  CHANNELS  sticky per-channel error
- err_count  out  ERR_CNT_WIDTH  saturating total error-event count
- busy  out  1  any channel in WAKE or SLEEP

Behaviour:
- Reset (async, active-high): pipelines 0, all states OFF, ck_gate 0, ch_state 0, error 0, err_count 0, busy 0.
- Inputs pass through PIPELINE_DEPTH register stages. en_p/mask_p/skip_p denote the last stage.
- Per-channel request: r = en_p & ~mask_p.
- States, with ch_state encoding: OFF=00, WAKE=01, ON=10, SLEEP=11.
- OFF:
  - skip_p -> ON.
  - else r with wake_delay==0 -> ON.
  - else r -> WAKE, cnt <= wake_delay.
- WAKE:
  - skip_p -> ON.
  - else !r -> OFF (abort; error event).
  - else cnt==1 -> ON.
  - else cnt--.
- ON:
  - skip_p or r -> stay.
  - else sleep_delay==0 -> OFF.
  - else SLEEP, cnt <= sleep_delay.
- SLEEP:
  - skip_p or r -> ON (re-arm, cnt discarded).
  - else cnt==1 -> OFF.
  - else cnt--.
- Delay latching: delays are sampled only on entry to WAKE/SLEEP. Changes mid-count are ignored.
- Timing: if r is first seen at last stage in cycle t while OFF, ck_gate rises at t+1+wake_delay. Fall is symmetric with sleep_delay.
- ck_gate is registered together with the state: it is 1 exactly when the state is ON or SLEEP.
- Error event per channel per cycle: (skip_p & mask_p) | (state==WAKE & !r & !skip_p).
- error[i] sets on an event and holds until err_clr.
- err_count adds popcount(events) each cycle and saturates at all-ones (no wrap).
- err_clr in the same cycle as events: error <= events, err_count <= popcount(events). Events win over the clear.
- Channels are fully independent; a cnt 4-bit field counts 1..2^DELAY_WIDTH-1.
- busy is registered: OR over channels of next-state in {WAKE, SLEEP}.
- Reset asserted mid-count returns to reset values immediately; no pending transitions survive.

Test Plan:
- Reset, then ck_en[0]=1, mask=0, wake_delay[0]=3 held -> ck_gate[0] rises exactly 2+1+3=6 cycles after ck_en rises; ch_state[1:0] shows 01 for 3 cycles, then 10; busy high during WAKE only.
- Channel 0 ON, sleep_delay=2, drop ck_en; re-raise ck_en one cycle into SLEEP -> ck_gate stays 1 throughout, state returns to ON, no error.
- ck_en[2]=1, wake_delay=5, drop ck_en after 2 WAKE cycles -> state OFF, ck_gate[2] never rises, error[2]=1, err_count=1.
- skip_req[3]=1 with qck_mask[3]=1 for 1 cycle from OFF -> ck_gate[3]=1 next cycle after pipeline; error[3]=1; err_count increments by 1.
- Force 4 channels into skip&mask conflict for 70 cycles with ERR_CNT_WIDTH=8 -> err_count saturates at 255, no wrap. err_clr coincident with a 4-channel event -> err_count=4, those error bits set.
- Assert reset while channel in WAKE (cnt=2) and another in SLEEP -> all ck_gate=0, ch_state=0, busy=0 immediately. After release, no gate rises without a new request.
